// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and defaults for the hazard/scoreboard unit.
// Operand-select encodings match the E-stage operand mux wiring.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_M  = 2'b00,
    FWD_RF = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle for the hazard unit: stage addresses/enables in, controls out.
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] raddr1D, raddr2D;
  logic              rs1_usedD, rs2_usedD, is_mcD;
  logic [REG_AW-1:0] raddr1E, raddr2E, waddrE;
  logic              reg_wrE, is_loadE, is_mcE;
  logic [REG_AW-1:0] waddrM, waddrW;
  logic              reg_wrM, reg_wrW;
  logic              mc_done;
  logic [REG_AW-1:0] mc_waddr;
  logic              br_taken;
  logic              StallF, StallD, FlushD, FlushE;
  logic [1:0]        For_A, For_B;
  logic              mc_busy;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  modport master (
    output raddr1D, raddr2D, rs1_usedD, rs2_usedD, is_mcD,
    output raddr1E, raddr2E, waddrE, reg_wrE, is_loadE, is_mcE,
    output waddrM, waddrW, reg_wrM, reg_wrW, mc_done, mc_waddr, br_taken,
    input  StallF, StallD, FlushD, FlushE, For_A, For_B, mc_busy,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  raddr1D, raddr2D, rs1_usedD, rs2_usedD, is_mcD,
    input  raddr1E, raddr2E, waddrE, reg_wrE, is_loadE, is_mcE,
    input  waddrM, waddrW, reg_wrM, reg_wrW, mc_done, mc_waddr, br_taken,
    output StallF, StallD, FlushD, FlushE, For_A, For_B, mc_busy,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit_reg_scoreboard.sv
// Pending-write bits for registers owned by the multi-cycle unit.
// Reads are of the registered vector only; a retire is visible next cycle.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int NREGS  = 2**REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic              pend1,
  output logic              pend2
);

  logic [NREGS-1:0] pending;

  // Set is applied after clear so a same-register issue beats a retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en && set_addr != '0) pending[set_addr] <= 1'b1;
    end
  end

  assign pend1 = pending[raddr1];
  assign pend2 = pending[raddr2];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding control for the 5-stage core with a scoreboard for the
// variable-latency mul/div unit and saturating stall/flush counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int NREGS  = 2**REG_AW,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_unit_if.slave hz
);

  logic [REG_AW-1:0] ra_d [2];
  logic [REG_AW-1:0] ra_e [2];
  logic              used_d [2];
  logic              pend [2];
  logic              hz_d [2];
  logic [1:0]        fwd [2];
  logic              mc_busy, stall;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  assign ra_d[0]   = hz.raddr1D;
  assign ra_d[1]   = hz.raddr2D;
  assign ra_e[0]   = hz.raddr1E;
  assign ra_e[1]   = hz.raddr2E;
  assign used_d[0] = hz.rs1_usedD;
  assign used_d[1] = hz.rs2_usedD;

  reg_scoreboard #(.REG_AW(REG_AW), .NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (hz.is_mcE && hz.reg_wrE),
    .set_addr (hz.waddrE),
    .clr_en   (hz.mc_done),
    .clr_addr (hz.mc_waddr),
    .raddr1   (hz.raddr1D),
    .raddr2   (hz.raddr2D),
    .pend1    (pend[0]),
    .pend2    (pend[1])
  );

  // Without forwarding, any in-flight producer in E/M/W blocks the reader.
  for (genvar i = 0; i < 2; i++) begin : g_src
    logic load_use, raw_any;
    assign load_use = hz.is_loadE && hz.reg_wrE && (ra_d[i] == hz.waddrE);
    assign raw_any  = (FWD_EN == 0) &&
                      ((hz.reg_wrE && ra_d[i] == hz.waddrE) ||
                       (hz.reg_wrM && ra_d[i] == hz.waddrM) ||
                       (hz.reg_wrW && ra_d[i] == hz.waddrW));
    assign hz_d[i]  = used_d[i] && (ra_d[i] != '0) && (load_use || pend[i] || raw_any);
    assign fwd[i]   = (FWD_EN == 0) ? FWD_RF :
                      (hz.reg_wrM && ra_e[i] == hz.waddrM && ra_e[i] != '0) ? FWD_M :
                      (hz.reg_wrW && ra_e[i] == hz.waddrW && ra_e[i] != '0) ? FWD_W :
                      FWD_RF;
  end

  // A taken branch kills the D instruction, so its hazards are irrelevant.
  assign stall = (hz_d[0] || hz_d[1] || (hz.is_mcD && mc_busy)) && !hz.br_taken;

  assign hz.StallF    = stall;
  assign hz.StallD    = stall;
  assign hz.FlushD    = hz.br_taken;
  assign hz.FlushE    = stall || hz.br_taken;
  assign hz.For_A     = fwd[0];
  assign hz.For_B     = fwd[1];
  assign hz.mc_busy   = mc_busy;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_busy   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.is_mcE)       mc_busy <= 1'b1;
      else if (hz.mc_done) mc_busy <= 1'b0;
      if (stall && stall_cnt != '1)         stall_cnt <= stall_cnt + 1'b1;
      if (hz.br_taken && flush_cnt != '1)   flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed checks for hazard_scoreboard_unit: one forwarding instance and one
// no-forwarding instance with narrow counters to reach saturation quickly.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   exp_stall = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_AW(5), .CNT_W(16)) hz ();
  hazard_scoreboard_unit_if #(.REG_AW(5), .CNT_W(4))  hn ();

  hazard_scoreboard_unit #(.REG_AW(5), .NREGS(32), .FWD_EN(1), .CNT_W(16)) u_dut (
    .clk (clk), .rst (rst), .hz (hz.slave)
  );
  hazard_scoreboard_unit #(.REG_AW(5), .NREGS(32), .FWD_EN(0), .CNT_W(4)) u_nf (
    .clk (clk), .rst (rst), .hz (hn.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // Advance to the next falling edge, where inputs are driven.
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    {hz.raddr1D, hz.raddr2D, hz.rs1_usedD, hz.rs2_usedD, hz.is_mcD} = '0;
    {hz.raddr1E, hz.raddr2E, hz.waddrE, hz.reg_wrE, hz.is_loadE, hz.is_mcE} = '0;
    {hz.waddrM, hz.waddrW, hz.reg_wrM, hz.reg_wrW} = '0;
    {hz.mc_done, hz.mc_waddr, hz.br_taken} = '0;
    {hn.raddr1D, hn.raddr2D, hn.rs1_usedD, hn.rs2_usedD, hn.is_mcD} = '0;
    {hn.raddr1E, hn.raddr2E, hn.waddrE, hn.reg_wrE, hn.is_loadE, hn.is_mcE} = '0;
    {hn.waddrM, hn.waddrW, hn.reg_wrM, hn.reg_wrW} = '0;
    {hn.mc_done, hn.mc_waddr, hn.br_taken} = '0;
  endtask

  initial begin
    clearInputs();
    #1;
    checkOutput("rst_For_A", 32'(hz.For_A), 32'h1);
    checkOutput("rst_For_B", 32'(hz.For_B), 32'h1);
    checkOutput("rst_stall", 32'({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}), 32'h0);
    checkOutput("rst_busy", 32'(hz.mc_busy), 32'h0);
    checkOutput("rst_cnts", {hz.stall_cnt, hz.flush_cnt}, 32'h0);
    applyStimulus();
    rst = 1'b0;

    // Forwarding priority M over W, then W, then register file.
    applyStimulus();
    hz.raddr1E = 5'd3; hz.waddrM = 5'd3; hz.reg_wrM = 1'b1; hz.waddrW = 5'd3; hz.reg_wrW = 1'b1;
    hz.raddr2E = 5'd3;
    #1;
    checkOutput("fwd_A_M", 32'(hz.For_A), 32'h0);
    checkOutput("fwd_B_M", 32'(hz.For_B), 32'h0);
    hz.reg_wrM = 1'b0;
    #1;
    checkOutput("fwd_A_W", 32'(hz.For_A), 32'h2);
    hz.raddr1E = 5'd0;
    #1;
    checkOutput("fwd_A_r0", 32'(hz.For_A), 32'h1);
    checkOutput("fwd_B_W", 32'(hz.For_B), 32'h2);

    // Load-use on rs2.
    applyStimulus();
    clearInputs();
    hz.is_loadE = 1'b1; hz.reg_wrE = 1'b1; hz.waddrE = 5'd5; hz.raddr2D = 5'd5; hz.rs2_usedD = 1'b1;
    #1;
    checkOutput("lu_ctrl", 32'({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}), 32'b1101);
    exp_stall++;
    applyStimulus();
    hz.rs2_usedD = 1'b0;
    #1;
    checkOutput("lu_unused", 32'({hz.StallF, hz.StallD, hz.FlushE}), 32'h0);

    // Scoreboard: issue mul to r7, reader stalls until the retire is registered.
    applyStimulus();
    clearInputs();
    hz.is_mcE = 1'b1; hz.reg_wrE = 1'b1; hz.waddrE = 5'd7;
    applyStimulus();
    clearInputs();
    hz.raddr1D = 5'd7; hz.rs1_usedD = 1'b1;
    #1;
    checkOutput("sb_busy", 32'(hz.mc_busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sb_hold%0d", i), 32'(hz.StallD), 32'h1);
      exp_stall++;
      applyStimulus();
    end
    hz.mc_done = 1'b1; hz.mc_waddr = 5'd7;
    #1;
    checkOutput("sb_done_cyc", 32'(hz.StallD), 32'h1);
    exp_stall++;
    applyStimulus();
    hz.mc_done = 1'b0;
    #1;
    checkOutput("sb_release", 32'(hz.StallD), 32'h0);
    checkOutput("sb_busy_clr", 32'(hz.mc_busy), 32'h0);
    checkOutput("sb_stall_cnt", 32'(hz.stall_cnt), 32'(exp_stall));

    // Structural hazard, then same-cycle retire and reissue to r9.
    applyStimulus();
    clearInputs();
    hz.is_mcE = 1'b1; hz.reg_wrE = 1'b1; hz.waddrE = 5'd9;
    applyStimulus();
    clearInputs();
    hz.is_mcD = 1'b1;
    #1;
    checkOutput("struct_stall", 32'(hz.StallD), 32'h1);
    exp_stall++;
    applyStimulus();
    clearInputs();
    hz.mc_done = 1'b1; hz.mc_waddr = 5'd9; hz.is_mcE = 1'b1; hz.reg_wrE = 1'b1; hz.waddrE = 5'd9;
    applyStimulus();
    clearInputs();
    hz.raddr1D = 5'd9; hz.rs1_usedD = 1'b1;
    #1;
    checkOutput("same_pend9", 32'(hz.StallD), 32'h1);
    checkOutput("same_busy", 32'(hz.mc_busy), 32'h1);
    exp_stall++;
    applyStimulus();
    hz.mc_done = 1'b1; hz.mc_waddr = 5'd9; hz.raddr1D = 5'd0;
    applyStimulus();
    clearInputs();
    hz.raddr1D = 5'd9; hz.rs1_usedD = 1'b1;
    #1;
    checkOutput("r9_retired", 32'(hz.StallD), 32'h0);
    checkOutput("r9_busy", 32'(hz.mc_busy), 32'h0);

    // Taken branch overrides a load-use stall.
    applyStimulus();
    clearInputs();
    hz.is_loadE = 1'b1; hz.reg_wrE = 1'b1; hz.waddrE = 5'd5; hz.raddr2D = 5'd5; hz.rs2_usedD = 1'b1;
    hz.br_taken = 1'b1;
    #1;
    checkOutput("br_ctrl", 32'({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}), 32'b0011);
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("br_flush_cnt", 32'(hz.flush_cnt), 32'h1);
    checkOutput("br_stall_cnt", 32'(hz.stall_cnt), 32'(exp_stall));

    // No-forwarding instance: RAW against M and W stalls, mux stays on RF.
    hn.raddr1D = 5'd4; hn.rs1_usedD = 1'b1; hn.raddr1E = 5'd4; hn.waddrM = 5'd4; hn.reg_wrM = 1'b1;
    #1;
    checkOutput("nf_raw_M", 32'(hn.StallD), 32'h1);
    checkOutput("nf_For_A", 32'(hn.For_A), 32'h1);
    applyStimulus();
    hn.reg_wrM = 1'b0; hn.waddrW = 5'd4; hn.reg_wrW = 1'b1;
    #1;
    checkOutput("nf_raw_W", 32'(hn.StallD), 32'h1);
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("nf_stall_cnt", 32'(hn.stall_cnt), 32'h2);

    // Narrow flush counter counts up, then saturates at 4'hF.
    hn.br_taken = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus();
    #1;
    checkOutput("nf_flush14", 32'(hn.flush_cnt), 32'd14);
    for (int i = 0; i < 3; i++) applyStimulus();
    #1;
    checkOutput("nf_flush_sat", 32'(hn.flush_cnt), 32'hF);
    hn.br_taken = 1'b0;

    // Asynchronous reset in the middle of an outstanding multi-cycle op.
    applyStimulus();
    hz.is_mcE = 1'b1; hz.reg_wrE = 1'b1; hz.waddrE = 5'd7;
    applyStimulus();
    clearInputs();
    hz.raddr1D = 5'd7; hz.rs1_usedD = 1'b1;
    #1;
    checkOutput("pre_rst_stall", 32'(hz.StallD), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", 32'(hz.mc_busy), 32'h0);
    checkOutput("arst_stall", 32'(hz.StallD), 32'h0);
    checkOutput("arst_cnts", {hz.stall_cnt, hz.flush_cnt}, 32'h0);
    checkOutput("arst_nf_cnt", 32'({hn.stall_cnt, hn.flush_cnt}), 32'h0);
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_pend", 32'(hz.StallD), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the pipeline hazard/forwarding unit for the 5-stage core: F, D, E, M, W stages. It keeps the M/W operand-forwarding muxes, the load-use stall and the branch flush. It adds a register scoreboard for a single multi-cycle execution unit (mul/div) with variable latency, a no-forwarding mode, and saturating stall/flush performance counters.

Parameters:
REG_AW, 5, register address width; register 0 is hard-wired zero.
NREGS, 32, number of architectural registers (2**REG_AW).
FWD_EN, 1, 1 = forward from M/W; 0 = no forwarding, stall on any in-flight RAW.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
raddr1D, raddr2D  in  REG_AW  decode-stage source addresses
rs1_usedD, rs2_usedD  in  1  decode instruction actually reads rs1/rs2
is_mcD  in  1  decode instruction is a multi-cycle op
raddr1E, raddr2E, waddrE  in  REG_AW  execute-stage addresses
reg_wrE, is_loadE, is_mcE  in  1  execute-stage writes reg / is load / is multi-cycle op
waddrM, waddrW  in  REG_AW  M/W destination addresses
reg_wrM, reg_wrW  in  1  M/W write enables
mc_done  in  1  multi-cycle unit result retires this cycle
mc_waddr  in  REG_AW  destination of the retiring result
br_taken  in  1  branch/jump resolved taken in E
StallF, StallD, FlushD, FlushE  out  1  pipeline controls
For_A, For_B  out  2  operand source select: 00 = M, 10 = W, 01 = register file
mc_busy  out  1  multi-cycle op outstanding
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (async, rst=1): pending[NREGS-1:0]=0, mc_busy=0, stall_cnt=0, flush_cnt=0. Control outputs are combinational; with all inputs at 0 they give For_A=For_B=01 and all stalls/flushes 0.
- Forwarding (FWD_EN=1, combinational, per operand X in {1,2}):
  - If raddrXE==waddrM && reg_wrM && raddrXE!=0 -> 00.
  - Else if the same condition holds against W -> 10.
  - Else -> 01.
  - M has priority over W.
- FWD_EN=0: For_A=For_B=01 always.
- hzD(X) = rsX_usedD && raddrXD!=0 && one of:
  - load-use: is_loadE && reg_wrE && raddrXD==waddrE;
  - scoreboard: pending[raddrXD]==1 (registered value only; a same-cycle mc_done does not bypass);
  - FWD_EN=0 only: any RAW match against E/M/W with the corresponding write enable set.
- Structural hazard: is_mcD && mc_busy.
- stall = (hzD(1) | hzD(2) | structural) & ~br_taken.
- Outputs:
  - StallF = StallD = stall.
  - FlushE = stall | br_taken.
  - FlushD = br_taken.
  - A taken branch overrides stalls because the D instruction is wrong-path.
- Scoreboard (posedge clk):
  - Set on issue: is_mcE && reg_wrE && waddrE!=0 sets pending[waddrE].
  - Clear on retire: mc_done clears pending[mc_waddr].
  - Same address set and clear in the same cycle: set wins.
  - pending[0] is never set.
- mc_busy (register):
  - Set on is_mcE issue, regardless of waddrE.
  - Cleared on mc_done.
  - Issue and done in the same cycle: busy stays 1.
  - mc_done while not busy: ignored for busy; the pending clear is still applied.
- Counters (posedge clk, saturate at all-ones, never wrap):
  - stall_cnt += 1 on each cycle with StallD=1.
  - flush_cnt += 1 on each cycle with br_taken=1.
- Latency: forwarding/stall outputs are zero-cycle combinational. Scoreboard and busy take effect the cycle after the issue/retire edge.

Decomposition:
- hazard_pkg: typedef enum logic [1:0] fwd_sel_e {FWD_M=2'b00, FWD_RF=2'b01, FWD_W=2'b10}; localparam REG_AW_DEF=5.
- One sub-module, reg_scoreboard: the pending vector, set/clear logic and the read ports for the two decode sources.

Test Plan:
1. Forwarding priority:
   - raddr1E=3, waddrM=3, reg_wrM=1, waddrW=3, reg_wrW=1 -> For_A=00.
   - Drop reg_wrM -> For_A=10.
   - raddr1E=0 -> For_A=01.
2. Load-use: is_loadE=1, reg_wrE=1, waddrE=5, raddr2D=5, rs2_usedD=1 -> StallF=StallD=FlushE=1, FlushD=0. With rs2_usedD=0 -> no stall.
3. Scoreboard:
   - Issue is_mcE, waddrE=7; next cycle raddr1D=7 -> stall held for every cycle until mc_done with mc_waddr=7.
   - Stall drops the cycle after mc_done.
   - stall_cnt equals the number of stalled cycles.
4. Structural/same-cycle: mc_busy=1 with is_mcD=1 -> stall. mc_done and a new is_mcE to the same reg 9 in the same cycle -> pending[9]=1, mc_busy=1.
5. Branch override: load-use condition plus br_taken=1 -> StallF=StallD=0, FlushD=FlushE=1, flush_cnt+1. Counter forced near all-ones -> saturates at 0xFFFF.
6. FWD_EN=0 and reset:
   - FWD_EN=0, RAW against M -> stall, For_A=01.
   - Assert rst mid-multi-cycle op -> pending=0 and mc_busy=0 immediately (asynchronously), and the stall clears.
